axo32_fetch: RTL
================

Name: axo32_fetch

Overview:
- Instruction fetch stage directly upstream of axo32_decoder.
- Owns the fetch PC and issues word reads on a simple req/ack instruction-memory port.
- Buffers returned words in a small FIFO and presents them, with their PC, to the decoder over a valid/ready handshake.
- Handles redirects (branch/jump/trap) from downstream, including discarding an in-flight response, and reports fetch faults.

Parameters:
- RESET_VEC, 32'h00000000, PC fetched first after reset (word aligned).
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_req  out  1  read request, registered.
- mem_addr  out  32  word address of request, registered; bits [1:0] always 0.
- mem_ack  in  1  request complete; mem_rdata/mem_err valid this cycle; only meaningful while mem_req=1.
- mem_rdata  in  32  returned instruction word.
- mem_err  in  1  bus error on this response.
- redir  in  1  redirect strobe; one cycle.
- redir_pc  in  32  new fetch PC.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decoder accepts head.
- inst  out  32  instruction word (0 for fault entries); feeds axo32_decoder inst.
- inst_pc  out  32  PC of inst.
- inst_fault  out  1  entry is a fetch fault (misaligned redirect or bus error).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_VEC, FIFO empty.
  - mem_req=0, mem_addr=RESET_VEC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
  - Reset mid-transaction abandons it; a late mem_ack is ignored since mem_req=0.
- Credit: free = FIFO_DEPTH - count. A request may be issued only when free > 0 after this cycle's pop. At most one request is outstanding, and it reserves one slot.
- Bus rule: once mem_req=1, mem_req and mem_addr hold stable until the mem_ack cycle. A request is never withdrawn. mem_ack may arrive in the same cycle mem_req is first seen high.
- States:
  - IDLE: mem_req=0.
    - If not redir and credit is available: mem_addr<=fetch_pc, mem_req<=1, go to BUSY.
    - First request therefore appears in the cycle after reset release.
  - BUSY: waiting for ack.
    - On mem_ack with mem_err=0: push {mem_rdata, mem_addr, fault=0}; fetch_pc+=4 (wraps mod 2^32). If credit remains (count after push and pop < DEPTH), stay in BUSY with mem_addr<=new fetch_pc, giving back-to-back requests (1 word/cycle with single-cycle ack). Otherwise mem_req<=0 and go to IDLE.
    - On mem_ack with mem_err=1: push {0, mem_addr, fault=1}; mem_req<=0; go to FAULT.
  - DISCARD: request was outstanding when a redirect arrived. mem_req/mem_addr are held. On mem_ack the data/error is dropped (no push) and the state machine proceeds as IDLE with the new fetch_pc (mem_req<=0).
  - FAULT: no requests issued. Leaves only via redir.
- Redirect, highest priority, any state:
  - FIFO flushed the same cycle; inst_valid=0 next cycle. A simultaneous pop is irrelevant.
  - fetch_pc<=redir_pc.
  - If BUSY/DISCARD without mem_ack: go to DISCARD.
  - If BUSY with mem_ack: response dropped; mem_req<=0; go to IDLE.
  - If IDLE/FAULT: go to IDLE.
  - If redir_pc[1:0]!=0: push {0, redir_pc, fault=1} instead and go to FAULT (via DISCARD first if a request is outstanding; the fault entry is pushed immediately).
  - A second redirect during DISCARD just replaces fetch_pc.
- FIFO:
  - Circular buffer with count.
  - Push and pop in the same cycle is allowed when full, provided credit was reserved.
  - Never overflows: push only occurs with a reserved slot.
  - Head is registered; outputs depend only on FIFO state, with no combinational path from mem_* or redir to inst_*.
  - inst/inst_pc/inst_fault hold stable while inst_valid=1 and inst_ready=0.
- Order: entries leave in fetch order; inst_pc of consecutive entries differs by 4 unless a redirect intervened.

Test Plan:
- Reset release, memory acks every request the same cycle, inst_ready=1: mem_addr sequence 0,4,8,…; inst_valid from cycle 2 onward, one instruction per cycle, inst_pc = address, inst = mem_rdata (e.g. 32'h00200193 at pc 0).
- inst_ready=0 with DEPTH=2: exactly 2 acks occur, then mem_req=0 and the FIFO holds pc 0 and 4 stable. Raise inst_ready: fetching resumes at pc 8.
- Ack latency 3 cycles, redir to 32'h100 one cycle after the request to pc 8: mem_req/mem_addr=8 held until ack; that data is never output; the next request is to 32'h100; the FIFO is empty after the redirect.
- redir_pc=32'h102: a single entry inst_fault=1, inst_pc=32'h102, inst=0; no further mem_req until redir to 32'h200, after which fetch resumes at 32'h200.
- mem_err on the ack for pc 12: entry inst_fault=1, inst_pc=12; the prior entries at pc 0/4/8 are delivered first; no further requests.
- rst_n pulsed low while BUSY: outputs reset asynchronously; after release the first request is to RESET_VEC.

Source files
------------

// File: rtl/axo32_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads,
// buffers responses in a small FIFO and hands them to the decoder with their PC.
module axo32_fetch #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DISCARD = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            fault;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_mem_req;
    logic            w_req_nxt;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] w_addr_nxt;
    logic            r_disc_fault;
    logic            w_disc_fault_nxt;

    entry_t          r_buf [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic            r_valid;

    logic            w_push;
    logic            w_flush;
    entry_t          w_push_entry;
    logic            w_pop;
    logic [CNT_W-1:0] w_cnt_after_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic            w_credit;
    logic            w_redir_mis;
    logic [XLEN-1:0] w_pc_inc;
    entry_t          w_head;

    assign w_pop           = r_valid & inst_ready;
    assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
    assign w_credit        = w_cnt_after_pop < CNT_W'(FIFO_DEPTH);
    assign w_redir_mis     = redir_pc[1:0] != 2'b00;
    assign w_pc_inc        = r_fetch_pc + XLEN'(4);

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_VEC;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= RESET_VEC;
            r_disc_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_pc_nxt;
            r_mem_req    <= w_req_nxt;
            r_mem_addr   <= w_addr_nxt;
            r_disc_fault <= w_disc_fault_nxt;
        end
    end

    // Next-state, request and push decisions; redirect overrides everything
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_fetch_pc;
        w_req_nxt        = r_mem_req;
        w_addr_nxt       = r_mem_addr;
        w_disc_fault_nxt = r_disc_fault;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        w_push_entry     = '0;

        if (redir) begin
            w_flush          = 1'b1;
            w_pc_nxt         = redir_pc;
            w_disc_fault_nxt = w_redir_mis;
            if (w_redir_mis) begin
                w_push       = 1'b1;
                w_push_entry = entry_t'{data: '0, pc: redir_pc, fault: 1'b1};
            end
            if (r_mem_req && !mem_ack) begin
                w_state_nxt = S_DISCARD;
            end else begin
                w_req_nxt   = 1'b0;
                w_state_nxt = w_redir_mis ? S_FAULT : S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_credit) begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_fetch_pc;
                        w_state_nxt = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        w_push = 1'b1;
                        if (mem_err) begin
                            w_push_entry = entry_t'{data: '0, pc: r_mem_addr, fault: 1'b1};
                            w_req_nxt    = 1'b0;
                            w_state_nxt  = S_FAULT;
                        end else begin
                            w_push_entry = entry_t'{data: mem_rdata, pc: r_mem_addr, fault: 1'b0};
                            w_pc_nxt     = w_pc_inc;
                            // The pushed word consumes the reserved slot; only chain if another is free
                            if ((w_cnt_after_pop + CNT_W'(1)) < CNT_W'(FIFO_DEPTH)) begin
                                w_addr_nxt = w_pc_inc;
                            end else begin
                                w_req_nxt   = 1'b0;
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = r_disc_fault ? S_FAULT : S_IDLE;
                    end
                end
                S_FAULT: begin
                    w_req_nxt = 1'b0;
                end
                default: begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_count_nxt = w_flush ? CNT_W'(w_push)
                                 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

    // Instruction buffer: circular array with occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '{default: '0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= w_count_nxt != '0;
            if (w_flush) begin
                r_rptr <= '0;
                if (w_push) begin
                    r_buf[0] <= w_push_entry;
                    r_wptr   <= PTR_W'(1);
                end else begin
                    r_wptr <= '0;
                end
            end else begin
                if (w_push) begin
                    r_buf[r_wptr] <= w_push_entry;
                    r_wptr        <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    assign w_head     = r_buf[r_rptr];
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = r_valid;
    assign inst       = w_head.data;
    assign inst_pc    = w_head.pc;
    assign inst_fault = w_head.fault;

endmodule
